ctrl_unit: RTL and testbench



---
 rtl/ctrl_pkg.sv | 72 +++++++
 rtl/ctrl_if.sv | 31 +++
 rtl/ctrl_prog_counter.sv | 21 ++
 rtl/ctrl_unit.sv | 170 +++++++++++++++++
 tb/tb_ctrl_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the instruction-sequencing controller.
// Holds opcode and ALU-select encodings, the controller state enum and the
// bit positions of the fields inside the 16-bit instruction word.
package ctrl_pkg;

    // Opcodes, IR[15:12]
    localparam logic [3:0] OP_NOOP  = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_NOT   = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'h9;

    // ALU function select driven onto the result-mux select lines
    localparam logic [2:0] ALU_ZERO = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_NOT  = 3'b110;

    // Instruction field positions
    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int RA_HI   = 11;
    localparam int RA_LO   = 8;
    localparam int RB_HI   = 7;
    localparam int RB_LO   = 4;
    localparam int RD_HI   = 3;
    localparam int RD_LO   = 0;
    localparam int DADR_HI = 11;
    localparam int DADR_LO = 4;

    typedef enum logic [3:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_NOOP,
        S_LOAD_A,
        S_LOAD_B,
        S_STORE,
        S_ALU,
        S_HALT
    } state_t;

    // Maps an ALU-class opcode to its function select; anything else is ZERO.
    function automatic logic [2:0] alu_sel(input logic [3:0] op);
        logic [2:0] sel;
        sel = ALU_ZERO;
        case (op)
            OP_ADD:  sel = ALU_ADD;
            OP_SUB:  sel = ALU_SUB;
            OP_AND:  sel = ALU_AND;
            OP_OR:   sel = ALU_OR;
            OP_XOR:  sel = ALU_XOR;
            OP_NOT:  sel = ALU_NOT;
            default: sel = ALU_ZERO;
        endcase
        return sel;
    endfunction

    // Opcodes above HALT have no defined meaning.
    function automatic logic is_illegal(input logic [3:0] op);
        return (op > OP_HALT);
    endfunction

endpackage

// File: rtl/ctrl_if.sv
// ctrl_if: signals between the sequencing controller and the datapath/ROM.
// master = controller side, slave = datapath/ROM side.
interface ctrl_if #(
    parameter int N    = 16,
    parameter int PC_W = 7
);
    logic [N-1:0]    instr;
    logic [PC_W-1:0] pc_addr;
    logic [7:0]      d_addr;
    logic            d_wr;
    logic [3:0]      rf_ra_addr;
    logic [3:0]      rf_rb_addr;
    logic [3:0]      rf_w_addr;
    logic            rf_w_en;
    logic            rf_s;
    logic [2:0]      alu_s0;
    logic            halt;
    logic            illegal;

    modport master (
        input  instr,
        output pc_addr, d_addr, d_wr, rf_ra_addr, rf_rb_addr, rf_w_addr,
               rf_w_en, rf_s, alu_s0, halt, illegal
    );

    modport slave (
        output instr,
        input  pc_addr, d_addr, d_wr, rf_ra_addr, rf_rb_addr, rf_w_addr,
               rf_w_en, rf_s, alu_s0, halt, illegal
    );
endinterface

// File: rtl/ctrl_prog_counter.sv
// prog_counter: PC_W-bit program counter with synchronous clear and
// increment enable. Wraps naturally from all-ones to zero.
module prog_counter #(
    parameter int PC_W = 7
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    // Clear wins over increment; otherwise count up when enabled.
    always_ff @(posedge clk) begin
        if (clr) begin
            pc <= '0;
        end else if (inc) begin
            pc <= pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/ctrl_unit.sv
// ctrl_unit: multi-cycle Moore controller for the 16-bit datapath.
// Fetches from program ROM, decodes, and drives register-file, data-memory
// and ALU-select controls. Outputs depend only on state and IR.
//
// Build option: CTRL_ILLEGAL_TRAP_EN -- when defined, opcodes 1010..1111
// trap into HALT with Illegal raised; otherwise they behave as NOOP.
//
// state    | meaning
// ---------+-------------------------------------------------------
// INIT     | post-reset idle cycle, all outputs low
// FETCH    | IR <= ROM word, PC advances
// DECODE   | opcode in IR selects the execute state
// NOOP     | no operation (also illegal opcodes when not trapping)
// LOAD_A   | present data-memory address
// LOAD_B   | write memory data into RF[Rd]
// STORE    | write RF[Ra] to data memory
// ALU      | RF[Rd] <= RF[Ra] op RF[Rb]
// HALT     | terminal until reset; PC and IR frozen
module ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int N    = 16,
    parameter int PC_W = 7
) (
    input  logic     clk,
    input  logic     reset,
    ctrl_if.master   bus
);

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    ir;
    logic [3:0]      opcode;
    logic            pc_inc;
    logic [PC_W-1:0] pc;

    logic [7:0]      d_addr;
    logic            d_wr;
    logic [3:0]      ra_addr;
    logic [3:0]      rb_addr;
    logic [3:0]      w_addr;
    logic            w_en;
    logic            rf_s;
    logic [2:0]      alu_s0;
    logic            halt;
    logic            illegal;

    assign opcode = ir[OPC_HI:OPC_LO];

    prog_counter #(.PC_W(PC_W)) u_pc (
        .clk (clk),
        .clr (reset),
        .inc (pc_inc),
        .pc  (pc)
    );

    // State register; reset overrides any state, including HALT and mid-LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Instruction register captures the ROM word only in FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir <= '0;
        end else if (state == S_FETCH) begin
            ir <= bus.instr;
        end
    end

    // Next-state logic and PC increment enable.
    always_comb begin
        state_nxt = state;
        pc_inc    = 1'b0;
        case (state)
            S_INIT:   state_nxt = S_FETCH;
            S_FETCH: begin
                state_nxt = S_DECODE;
                pc_inc    = 1'b1;
            end
            S_DECODE: begin
                case (opcode)
                    OP_NOOP:  state_nxt = S_NOOP;
                    OP_LOAD:  state_nxt = S_LOAD_A;
                    OP_STORE: state_nxt = S_STORE;
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT:
                              state_nxt = S_ALU;
                    OP_HALT:  state_nxt = S_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:  state_nxt = S_HALT;
`else
                    default:  state_nxt = S_NOOP;
`endif
                endcase
            end
            S_LOAD_A: state_nxt = S_LOAD_B;
            S_LOAD_B: state_nxt = S_FETCH;
            S_NOOP:   state_nxt = S_FETCH;
            S_STORE:  state_nxt = S_FETCH;
            S_ALU:    state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_INIT;
        endcase
    end

    // Moore output decode from state and IR fields.
    always_comb begin
        d_addr  = 8'h00;
        d_wr    = 1'b0;
        ra_addr = 4'h0;
        rb_addr = 4'h0;
        w_addr  = 4'h0;
        w_en    = 1'b0;
        rf_s    = 1'b0;
        alu_s0  = ALU_ZERO;
        halt    = 1'b0;
        case (state)
            S_LOAD_A: begin
                d_addr = ir[DADR_HI:DADR_LO];
            end
            S_LOAD_B: begin
                d_addr = ir[DADR_HI:DADR_LO];
                w_addr = ir[RD_HI:RD_LO];
                rf_s   = 1'b1;
                w_en   = 1'b1;
            end
            S_STORE: begin
                d_addr  = ir[DADR_HI:DADR_LO];
                ra_addr = ir[RD_HI:RD_LO];
                d_wr    = 1'b1;
            end
            S_ALU: begin
                ra_addr = ir[RA_HI:RA_LO];
                rb_addr = ir[RB_HI:RB_LO];
                w_addr  = ir[RD_HI:RD_LO];
                alu_s0  = alu_sel(opcode);
                w_en    = 1'b1;
            end
            S_HALT: begin
                halt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // An illegal trap is a HALT whose IR still holds the offending opcode.
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal = (state == S_HALT) && is_illegal(opcode);
`else
    assign illegal = 1'b0;
`endif

    assign bus.pc_addr    = pc;
    assign bus.d_addr     = d_addr;
    assign bus.d_wr       = d_wr;
    assign bus.rf_ra_addr = ra_addr;
    assign bus.rf_rb_addr = rb_addr;
    assign bus.rf_w_addr  = w_addr;
    assign bus.rf_w_en    = w_en;
    assign bus.rf_s       = rf_s;
    assign bus.alu_s0     = alu_s0;
    assign bus.halt       = halt;
    assign bus.illegal    = illegal;

endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: bench for ctrl_unit. Instruction vectors with hand-derived
// expected per-cycle outputs are expanded into a queue of expected
// observations, which are popped and compared one per clock.
module tb_ctrl_unit;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ctrl_if #(.N(16), .PC_W(7)) bus ();

    logic [15:0] rom [0:127];
    assign bus.instr = rom[bus.pc_addr];

    ctrl_unit #(.N(16), .PC_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [6:0] pc;
        logic [7:0] d_addr;
        logic       d_wr;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] wa;
        logic       wen;
        logic       rfs;
        logic [2:0] alu;
        logic       halt;
        logic       ill;
    } obs_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [1:0]  ncyc;
        obs_t        e1;
        obs_t        e2;
    } vec_t;

    vec_t  vt [0:11];
    string vn [0:11];
    obs_t  q  [$];
    string qn [$];
    int    n_vec  = 0;
    int    n_miss = 0;

    function automatic obs_t mk(input logic [7:0] da, input logic dw,
                                input logic [3:0] ra, input logic [3:0] rb,
                                input logic [3:0] wa, input logic wen,
                                input logic rfs, input logic [2:0] alu,
                                input logic h, input logic il);
        obs_t o;
        o.pc = 7'd0; o.d_addr = da; o.d_wr = dw; o.ra = ra; o.rb = rb;
        o.wa = wa; o.wen = wen; o.rfs = rfs; o.alu = alu; o.halt = h;
        o.ill = il;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.pc = bus.pc_addr; o.d_addr = bus.d_addr; o.d_wr = bus.d_wr;
        o.ra = bus.rf_ra_addr; o.rb = bus.rf_rb_addr; o.wa = bus.rf_w_addr;
        o.wen = bus.rf_w_en; o.rfs = bus.rf_s; o.alu = bus.alu_s0;
        o.halt = bus.halt; o.ill = bus.illegal;
        return o;
    endfunction

    task automatic push(input string nm, input obs_t o);
        q.push_back(o);
        qn.push_back(nm);
    endtask

    task automatic check_next();
        obs_t  exp_o;
        obs_t  act_o;
        string nm;
        @(negedge clk);
        exp_o = q.pop_front();
        nm    = qn.pop_front();
        act_o = sample();
        n_vec++;
        if (act_o !== exp_o) begin
            n_miss++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act_o, exp_o);
        end
    endtask

    task automatic drain();
        while (q.size() > 0) check_next();
    endtask

    // Reset held for one cycle; the cycle after shows INIT with all outputs 0.
    task automatic do_reset();
        reset = 1'b1;
        push("reset_init", mk(8'h00, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0));
        check_next();
        reset = 1'b0;
    endtask

    // Place a vector at ROM address p and expect FETCH, DECODE, execute.
    task automatic run_vec(input int idx, input logic [6:0] p);
        obs_t       o;
        logic [6:0] pn;
        pn = p + 7'd1;
        rom[p] = vt[idx].instr;
        o = mk(8'h00, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0);
        o.pc = p;
        push({vn[idx], "_fetch"}, o);
        o.pc = pn;
        push({vn[idx], "_decode"}, o);
        o = vt[idx].e1;
        o.pc = pn;
        push({vn[idx], "_exec1"}, o);
        if (vt[idx].ncyc == 2'd2) begin
            o = vt[idx].e2;
            o.pc = pn;
            push({vn[idx], "_exec2"}, o);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        reset = 1'b1;
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;

        vn[0]  = "add";   vt[0]  = '{16'h3123, 2'd1, mk(8'h00,0,4'h1,4'h2,4'h3,1,0,3'b001,0,0), '0};
        vn[1]  = "load";  vt[1]  = '{16'h1A55, 2'd2, mk(8'hA5,0,0,0,0,0,0,3'b000,0,0),
                                                     mk(8'hA5,0,0,0,4'h5,1,1,3'b000,0,0)};
        vn[2]  = "store"; vt[2]  = '{16'h2F07, 2'd1, mk(8'hF0,1,4'h7,0,0,0,0,3'b000,0,0), '0};
        vn[3]  = "sub";   vt[3]  = '{16'h4A6C, 2'd1, mk(8'h00,0,4'hA,4'h6,4'hC,1,0,3'b010,0,0), '0};
        vn[4]  = "not";   vt[4]  = '{16'h8F0D, 2'd1, mk(8'h00,0,4'hF,4'h0,4'hD,1,0,3'b110,0,0), '0};
        vn[5]  = "halt";  vt[5]  = '{16'h9000, 2'd1, mk(8'h00,0,0,0,0,0,0,3'b000,1,0), '0};
        vn[6]  = "and";   vt[6]  = '{16'h5123, 2'd1, mk(8'h00,0,4'h1,4'h2,4'h3,1,0,3'b011,0,0), '0};
        vn[7]  = "or";    vt[7]  = '{16'h6456, 2'd1, mk(8'h00,0,4'h4,4'h5,4'h6,1,0,3'b100,0,0), '0};
        vn[8]  = "xor";   vt[8]  = '{16'h7789, 2'd1, mk(8'h00,0,4'h7,4'h8,4'h9,1,0,3'b101,0,0), '0};
        vn[9]  = "noop";  vt[9]  = '{16'h0000, 2'd1, mk(8'h00,0,0,0,0,0,0,3'b000,0,0), '0};
`ifdef CTRL_ILLEGAL_TRAP_EN
        vn[10] = "illegal"; vt[10] = '{16'hF000, 2'd1, mk(8'h00,0,0,0,0,0,0,3'b000,1,1), '0};
`else
        vn[10] = "illegal"; vt[10] = '{16'hF000, 2'd1, mk(8'h00,0,0,0,0,0,0,3'b000,0,0), '0};
`endif
        vn[11] = "load2"; vt[11] = '{16'h10F3, 2'd2, mk(8'h0F,0,0,0,0,0,0,3'b000,0,0),
                                                     mk(8'h0F,0,0,0,4'h3,1,1,3'b000,0,0)};

        // Program 1: ADD, LOAD, STORE, SUB, NOT, HALT at address 5
        do_reset();
        for (int i = 0; i <= 5; i++) run_vec(i, 7'(i));
        o = mk(8'h00, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0);
        o.pc = 7'd6;
        for (int i = 0; i < 20; i++) push("halt_hold", o);
        drain();
        do_reset();

        // Program 2: remaining ALU ops, NOOP, second LOAD, illegal opcode
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        run_vec(6, 7'd0);
        run_vec(7, 7'd1);
        run_vec(8, 7'd2);
        run_vec(9, 7'd3);
        run_vec(11, 7'd4);
        run_vec(10, 7'd5);
`ifdef CTRL_ILLEGAL_TRAP_EN
        o = mk(8'h00, 0, 0, 0, 0, 0, 0, 3'd0, 1, 1);
        o.pc = 7'd6;
        for (int i = 0; i < 5; i++) push("illegal_hold", o);
        drain();
`else
        run_vec(5, 7'd6);
`endif
        do_reset();

        // PC wrap: ADD at 0, NOOPs through 127, then fetch from 0 again
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        run_vec(0, 7'd0);
        for (int k = 1; k < 128; k++) run_vec(9, 7'(k));
        run_vec(0, 7'd0);
        do_reset();

        // Reset during LOAD_A: the load is abandoned without an RF write
        rom[0] = 16'h1A55;
        o = mk(8'h00, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0);
        o.pc = 7'd0;
        push("abort_fetch", o);
        o.pc = 7'd1;
        push("abort_decode", o);
        o = vt[1].e1;
        o.pc = 7'd1;
        push("abort_load_a", o);
        drain();
        rom[0] = 16'h0000;
        do_reset();
        run_vec(9, 7'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
